xor_rr_scheduler: RTL and testbench

//   Shares one W-bit XOR datapath (xor_unit, Y = A ^ B) between NREQ requesters.

---
 rtl/xor_rr_scheduler_pkg.sv | 13 +
 rtl/xor_rr_scheduler_xor.sv | 13 +
 rtl/xor_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_xor_rr_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_rr_scheduler_pkg.sv
// Shared definitions for the round-robin XOR scheduler.
// Holds the result-slot state encoding and default sizing.
package xor_rr_scheduler_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/xor_rr_scheduler_xor.sv
// Shared W-bit XOR datapath.
// Purely combinational, one instance behind the operand mux.
module xor_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_rr_scheduler.sv
// Round-robin arbiter sharing one XOR unit among NREQ requesters.
// Result is held in a single registered valid/ready slot.
module xor_rr_scheduler
    import xor_rr_scheduler_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_y,
    output logic [IDW-1:0]    res_id
);

    slot_state_e    state_q;
    slot_state_e    state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [W-1:0]   res_y_q;
    logic [W-1:0]   res_y_d;
    logic [IDW-1:0] res_id_q;
    logic [IDW-1:0] res_id_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic           slot_free;
    logic           accept;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   xor_y;

    // Scan requesters starting at rr_ptr; first valid one wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign slot_free = (state_q == ST_EMPTY) | (res_valid & res_ready);
    // Gated by rst_n so no grant leaks out while reset is held.
    assign accept    = rst_n & slot_free & win_found;

    // One-hot grant to the winner when the slot can take a result.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign a_sel = req_a[int'(win_idx)*W +: W];
    assign b_sel = req_b[int'(win_idx)*W +: W];

    xor_unit #(
        .W (W)
    ) u_xor (
        .a_i (a_sel),
        .b_i (b_sel),
        .y_o (xor_y)
    );

    // Slot FSM next state; a consume plus accept stays FULL.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (res_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result data and pointer only move on an accept.
    always_comb begin
        res_y_d  = res_y_q;
        res_id_d = res_id_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            res_y_d  = xor_y;
            res_id_d = win_idx;
            if (win_idx == IDW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result payload and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y_q  <= '0;
            res_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            res_y_q  <= res_y_d;
            res_id_q <= res_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign res_y  = res_y_q;
    assign res_id = res_id_q;

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Self-checking bench for xor_rr_scheduler.
// Directed scenarios plus randomized traffic against a reference model.
module tb_xor_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_y;
    logic [1:0]        res_id;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit              m_full;
    logic [W-1:0]    m_y;
    int              m_id;
    int              m_ptr;
    logic [NREQ-1:0] last_grant;

    xor_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    function automatic int exp_win(logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int w;
        logic [NREQ-1:0] r;
        r = '0;
        w = exp_win(req_valid);
        if (rst_n && (!m_full || res_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0; m_y = '0; m_id = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int w;
        last_grant = exp_ready();
        w = exp_win(req_valid);
        if (!rst_n) begin
            model_reset();
        end else if (last_grant != 0) begin
            m_full = 1;
            m_y    = req_a[w*W +: W] ^ req_b[w*W +: W];
            m_id   = w;
            m_ptr  = (w + 1) % NREQ;
        end else if (m_full && res_ready) begin
            m_full = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n = 0;
        req_valid = '0;
        res_ready = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int c = 0; c < 4; c++) begin
            req_valid = NREQ'($urandom);
            req_a = $urandom; req_b = $urandom;
            res_ready = 1'($urandom);
            #1;
            vectors++;
            if (req_ready !== 4'b0 || res_valid !== 1'b0 ||
                res_y !== 8'h00 || res_id !== 2'd0) begin
                miscompares++;
                $display("FAIL reset rdy=%b v=%b y=%h id=%0d want 0,0,0,0",
                         req_ready, res_valid, res_y, res_id);
            end
            tick();
        end
        req_valid = '0;
        rst_n = 1;
    endtask

    task automatic test_single();
        set_op(2, 8'hA5, 8'h0F);
        req_valid = 4'b0100;
        res_ready = 1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (res_y !== 8'hAA || res_id !== 2'd2 || res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_res got y=%h id=%0d v=%b want AA 2 1",
                     res_y, res_id, res_valid);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain got v=%b want 0", res_valid);
        end
    endtask

    task automatic test_fairness();
        logic [W-1:0] ey;
        do_reset();
        req_a = $urandom; req_b = $urandom;
        req_valid = 4'b1111;
        res_ready = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                miscompares++;
                $display("FAIL fair_ready[%0d] got %b want %b",
                         k, req_ready, 4'b0001 << (k % 4));
            end
            ey = req_a[(k%4)*W +: W] ^ req_b[(k%4)*W +: W];
            tick();
            vectors++;
            if (res_id !== 2'(k % 4) || res_valid !== 1'b1 || res_y !== ey) begin
                miscompares++;
                $display("FAIL fair_res[%0d] got id=%0d v=%b y=%h want %0d 1 %h",
                         k, res_id, res_valid, res_y, k % 4, ey);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ey;
        do_reset();
        set_op(0, 8'h3C, 8'h00);
        req_valid = 4'b0001;
        res_ready = 1;
        tick();
        set_op(1, W'($urandom), W'($urandom));
        req_valid = 4'b1111;
        res_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0 || res_y !== 8'h3C ||
                res_id !== 2'd0 || res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got rdy=%b y=%h id=%0d v=%b want 0000 3C 0 1",
                         c, req_ready, res_y, res_id, res_valid);
            end
            tick();
        end
        res_ready = 1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_release_ready got %b want 0010", req_ready);
        end
        ey = req_a[W +: W] ^ req_b[W +: W];
        tick();
        vectors++;
        if (res_id !== 2'd1 || res_y !== ey || res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next got id=%0d y=%h v=%b want 1 %h 1",
                     res_id, res_y, res_valid, ey);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req_a = $urandom; req_b = $urandom;
        res_ready = 1;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_skip got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b1001;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_from2 got %b want 1000", req_ready);
        end
        tick();
        vectors++;
        if (res_id !== 2'd3) begin
            miscompares++;
            $display("FAIL wrap_id3 got %0d want 3", res_id);
        end
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_to0 got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_a = $urandom; req_b = $urandom;
        req_valid = 4'b0010;
        res_ready = 0;
        tick();
        req_valid = '0;
        vectors++;
        if (res_id !== 2'd1 || res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_full got id=%0d v=%b want 1 1", res_id, res_valid);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        vectors++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL midop_async got v=%b rdy=%b want 0 0000",
                     res_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1;
        req_valid = 4'b1111;
        res_ready = 1;
        tick();
        vectors++;
        if (res_id !== 2'd0 || res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_restart got id=%0d v=%b want 0 1", res_id, res_valid);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        last_grant = '0;
        for (int c = 0; c < 400; c++) begin
            vectors++;
            if (res_valid !== 1'(m_full) ||
                (m_full && (res_y !== m_y || res_id !== 2'(m_id)))) begin
                miscompares++;
                $display("FAIL rand_res[%0d] got v=%b y=%h id=%0d want %0d %h %0d",
                         c, res_valid, res_y, res_id, m_full, m_y, m_id);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_grant[i]) begin
                    req_valid[i] = 1'($urandom);
                    set_op(i, W'($urandom), W'($urandom));
                end
            end
            res_ready = ($urandom % 4) != 0;
            #1;
            vectors++;
            if (req_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_ready[%0d] got %b want %b",
                         c, req_ready, exp_ready());
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 0;
        model_reset();
        last_grant = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
